// File: rtl/exception_responder.sv
// Exception responder: captures the faulting PC and cause, flushes the pipeline,
// redirects fetch to the handler vector and returns to EPC+4 on eret.
module exception_responder #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] VECTOR_ADDR = ADDR_W'(32'h0000_0180)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exc_flag,
  input  logic              exc_overflow,
  input  logic              exc_invalid_addr,
  input  logic              exc_div_zero,
  input  logic              exc_control,
  input  logic              exc_write2_0,
  input  logic [ADDR_W-1:0] exc_pc,
  input  logic              eret,
  output logic              flush,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_target,
  output logic [ADDR_W-1:0] epc,
  output logic [2:0]        cause_code,
  output logic [4:0]        cause_mask,
  output logic              exl,
  output logic              double_fault
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLUSH    = 3'd1,
    REDIRECT = 3'd2,
    HANDLER  = 3'd3,
    RETURN   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [2:0]        code_q, code_d;
  logic [4:0]        mask_q, mask_d;
  logic              exl_q, exl_d;
  logic              df_q, df_d;

  logic [4:0] causes;
  logic       trigger;

  assign causes  = {exc_write2_0, exc_control, exc_overflow, exc_div_zero, exc_invalid_addr};
  assign trigger = exc_flag | (|causes);

  // Lowest-numbered cause wins; a bare exc_flag reports the "unknown" code 7.
  function automatic logic [2:0] prioritize(input logic [4:0] m);
    logic [2:0] code;
    code = 3'd7;
    if (m[0])      code = 3'd1;
    else if (m[1]) code = 3'd2;
    else if (m[2]) code = 3'd3;
    else if (m[3]) code = 3'd4;
    else if (m[4]) code = 3'd5;
    return code;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      epc_q   <= '0;
      code_q  <= '0;
      mask_q  <= '0;
      exl_q   <= 1'b0;
      df_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      code_q  <= code_d;
      mask_q  <= mask_d;
      exl_q   <= exl_d;
      df_q    <= df_d;
    end
  end

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    code_d  = code_q;
    mask_d  = mask_q;
    exl_d   = exl_q;
    df_d    = df_q;

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          epc_d   = exc_pc;
          mask_d  = causes;
          code_d  = prioritize(causes);
          exl_d   = 1'b1;
          state_d = FLUSH;
        end
      end
      FLUSH:    state_d = REDIRECT;
      REDIRECT: state_d = HANDLER;
      HANDLER: begin
        if (eret) state_d = RETURN;
      end
      RETURN: begin
        exl_d   = 1'b0;
        state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase

    // Any trigger while already servicing is dropped but remembered until reset.
    if (state_q != IDLE && trigger) df_d = 1'b1;
  end

  always_comb begin
    flush       = (state_q == FLUSH);
    pc_redirect = (state_q == REDIRECT) || (state_q == RETURN);
    pc_target   = '0;
    if (state_q == REDIRECT)    pc_target = VECTOR_ADDR;
    else if (state_q == RETURN) pc_target = epc_q + ADDR_W'(4);
  end

  assign epc          = epc_q;
  assign cause_code   = code_q;
  assign cause_mask   = mask_q;
  assign exl          = exl_q;
  assign double_fault = df_q;

endmodule

// File: tb/tb_exception_responder.sv
// Self-checking bench for exception_responder: an age-based behavioural model
// checked every cycle, plus hand-computed expectations at key points.
module tb_exception_responder;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] VEC    = 32'h0000_0180;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        excFlag;
  logic [4:0]  causeIn;
  logic [31:0] excPc;
  logic        eretIn;

  logic        flush;
  logic        pcRedirect;
  logic [31:0] pcTarget;
  logic [31:0] epc;
  logic [2:0]  causeCode;
  logic [4:0]  causeMask;
  logic        exl;
  logic        doubleFault;

  int checks = 0;
  int errors = 0;
  bit compareOn = 1'b0;

  always #5 clk = ~clk;

  exception_responder #(
    .ADDR_W      (ADDR_W),
    .VECTOR_ADDR (VEC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .exc_flag         (excFlag),
    .exc_overflow     (causeIn[2]),
    .exc_invalid_addr (causeIn[0]),
    .exc_div_zero     (causeIn[1]),
    .exc_control      (causeIn[3]),
    .exc_write2_0     (causeIn[4]),
    .exc_pc           (excPc),
    .eret             (eretIn),
    .flush            (flush),
    .pc_redirect      (pcRedirect),
    .pc_target        (pcTarget),
    .epc              (epc),
    .cause_code       (causeCode),
    .cause_mask       (causeMask),
    .exl              (exl),
    .double_fault     (doubleFault)
  );

  // Model: mAge counts cycles since capture (1 = flush, 2 = vector redirect,
  // 3 = waiting in handler); mRet marks the single return-redirect cycle.
  bit          mSvc, mRet, mDf;
  int          mAge;
  logic [31:0] mEpc;
  logic [4:0]  mMask;
  logic [2:0]  mCode;

  function automatic logic [2:0] expectCode(input logic [4:0] m);
    if (m[0]) return 3'd1;
    if (m[1]) return 3'd2;
    if (m[2]) return 3'd3;
    if (m[3]) return 3'd4;
    if (m[4]) return 3'd5;
    return 3'd7;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mSvc  <= 1'b0;
      mRet  <= 1'b0;
      mDf   <= 1'b0;
      mAge  <= 0;
      mEpc  <= '0;
      mMask <= '0;
      mCode <= '0;
    end else if (!mSvc) begin
      if (excFlag || causeIn != 5'd0) begin
        mSvc  <= 1'b1;
        mAge  <= 1;
        mRet  <= 1'b0;
        mEpc  <= excPc;
        mMask <= causeIn;
        mCode <= expectCode(causeIn);
      end
    end else begin
      if (excFlag || causeIn != 5'd0) mDf <= 1'b1;
      if (mRet) begin
        mSvc <= 1'b0;
        mRet <= 1'b0;
      end else if (mAge >= 3 && eretIn) begin
        mRet <= 1'b1;
      end else if (mAge < 3) begin
        mAge <= mAge + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (compareOn) begin : compareBlock
      logic        eFlush, eRedir;
      logic [31:0] eTarget;
      eFlush  = mSvc && !mRet && (mAge == 1);
      eRedir  = mSvc && (mRet || mAge == 2);
      eTarget = !eRedir ? 32'h0 : (mRet ? mEpc + 32'd4 : VEC);
      checkOutput("model.flush",        {31'd0, flush},        {31'd0, eFlush});
      checkOutput("model.pc_redirect",  {31'd0, pcRedirect},   {31'd0, eRedir});
      checkOutput("model.pc_target",    pcTarget,              eTarget);
      checkOutput("model.epc",          epc,                   mEpc);
      checkOutput("model.cause_code",   {29'd0, causeCode},    {29'd0, mCode});
      checkOutput("model.cause_mask",   {27'd0, causeMask},    {27'd0, mMask});
      checkOutput("model.exl",          {31'd0, exl},          {31'd0, mSvc});
      checkOutput("model.double_fault", {31'd0, doubleFault},  {31'd0, mDf});
    end
  end

  // Drive one cycle of inputs starting at a falling edge; pulses drop afterwards.
  task automatic applyStimulus(input logic flag, input logic [4:0] cm, input logic [31:0] pc, input logic er);
    excFlag = flag;
    causeIn = cm;
    excPc   = pc;
    eretIn  = er;
    @(negedge clk);
    excFlag = 1'b0;
    causeIn = 5'd0;
    eretIn  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".flush"},        {31'd0, flush},       32'd0);
    checkOutput({tag, ".pc_redirect"},  {31'd0, pcRedirect},  32'd0);
    checkOutput({tag, ".pc_target"},    pcTarget,             32'd0);
    checkOutput({tag, ".epc"},          epc,                  32'd0);
    checkOutput({tag, ".cause_code"},   {29'd0, causeCode},   32'd0);
    checkOutput({tag, ".cause_mask"},   {27'd0, causeMask},   32'd0);
    checkOutput({tag, ".exl"},          {31'd0, exl},         32'd0);
    checkOutput({tag, ".double_fault"}, {31'd0, doubleFault}, 32'd0);
  endtask

  initial begin
    rst_n   = 1'b1;
    excFlag = 1'b0;
    causeIn = 5'd0;
    excPc   = 32'd0;
    eretIn  = 1'b0;
    #1 rst_n = 1'b0;
    compareOn = 1'b1;
    @(negedge clk);
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    $display("[TB] overflow only");
    applyStimulus(1'b0, 5'b00100, 32'h0000_0040, 1'b0);
    checkOutput("ovf.flush", {31'd0, flush}, 32'd1);
    checkOutput("ovf.epc", epc, 32'h40);
    checkOutput("ovf.cause_code", {29'd0, causeCode}, 32'd3);
    checkOutput("ovf.cause_mask", {27'd0, causeMask}, 32'b00100);
    checkOutput("ovf.exl", {31'd0, exl}, 32'd1);
    idle(1);
    checkOutput("ovf.redirect", {31'd0, pcRedirect}, 32'd1);
    checkOutput("ovf.vector", pcTarget, 32'h180);
    idle(1);
    checkOutput("ovf.handler_target", pcTarget, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    checkOutput("ovf.ret_target", pcTarget, 32'h44);
    idle(1);
    checkOutput("ovf.exl_after", {31'd0, exl}, 32'd0);

    $display("[TB] multiple causes");
    applyStimulus(1'b1, 5'b10011, 32'h0000_0200, 1'b0);
    checkOutput("multi.cause_code", {29'd0, causeCode}, 32'd1);
    checkOutput("multi.cause_mask", {27'd0, causeMask}, 32'b10011);
    idle(3);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    checkOutput("multi.ret_redirect", {31'd0, pcRedirect}, 32'd1);
    checkOutput("multi.ret_target", pcTarget, 32'h204);
    idle(1);
    checkOutput("multi.exl_after", {31'd0, exl}, 32'd0);

    $display("[TB] flag without cause");
    applyStimulus(1'b1, 5'd0, 32'h0000_0300, 1'b0);
    checkOutput("unk.cause_code", {29'd0, causeCode}, 32'd7);
    checkOutput("unk.flush", {31'd0, flush}, 32'd1);
    idle(1);
    checkOutput("unk.vector", pcTarget, 32'h180);
    idle(2);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    idle(1);

    $display("[TB] nested trigger");
    applyStimulus(1'b0, 5'b00100, 32'h0000_0500, 1'b0);
    idle(2);
    applyStimulus(1'b0, 5'b01000, 32'h0000_0100, 1'b0);
    checkOutput("nest.double_fault", {31'd0, doubleFault}, 32'd1);
    checkOutput("nest.epc", epc, 32'h500);
    checkOutput("nest.cause_code", {29'd0, causeCode}, 32'd3);
    applyStimulus(1'b1, 5'd0, 32'h0000_0100, 1'b1);
    checkOutput("nest.ret_target", pcTarget, 32'h504);
    idle(1);
    checkOutput("nest.df_sticky", {31'd0, doubleFault}, 32'd1);

    $display("[TB] wrap and idle eret");
    applyStimulus(1'b0, 5'b00001, 32'hFFFF_FFFC, 1'b0);
    idle(2);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    checkOutput("wrap.redirect", {31'd0, pcRedirect}, 32'd1);
    checkOutput("wrap.target", pcTarget, 32'h0);
    idle(1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    checkOutput("idle_eret.redirect", {31'd0, pcRedirect}, 32'd0);
    checkOutput("idle_eret.df_sticky", {31'd0, doubleFault}, 32'd1);

    $display("[TB] reset mid-sequence");
    applyStimulus(1'b0, 5'b00010, 32'h0000_0600, 1'b0);
    idle(1);
    checkOutput("mid.redirect", {31'd0, pcRedirect}, 32'd1);
    #2 rst_n = 1'b0;
    #1 checkAllZero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 5'b00010, 32'h0000_0700, 1'b0);
    checkOutput("restart.flush", {31'd0, flush}, 32'd1);
    checkOutput("restart.cause_code", {29'd0, causeCode}, 32'd2);
    checkOutput("restart.df", {31'd0, doubleFault}, 32'd0);
    idle(1);
    checkOutput("restart.vector", pcTarget, 32'h180);
    idle(1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    checkOutput("restart.ret_target", pcTarget, 32'h704);
    idle(2);

    compareOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/exception_responder.md
# exception_responder

Sequential consumer of the processor's exception-raise signals. It samples the per-cause exception lines and the aggregate exception flag, records the faulting PC and cause, flushes the pipeline and redirects fetch to the handler vector. On handler return (`eret`) it redirects fetch to the instruction after the faulting one. It sits between the exception-flag generator and the PC-select/pipeline-control logic of the simplified MIPS core.

## Interface
Parameters:
- `ADDR_W`, 32, PC/address width.
- `VECTOR_ADDR`, 32'h0000_0180, handler entry address.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `exc_flag`  in  1  aggregate exception-raise flag.
- `exc_overflow`, `exc_invalid_addr`, `exc_div_zero`, `exc_control`, `exc_write2_0`  in  1 each  individual cause lines.
- `exc_pc`  in  ADDR_W  PC of the instruction raising the exception.
- `eret`  in  1  handler-return request, single-cycle pulse.
- `flush`  out  1  pipeline flush pulse.
- `pc_redirect`  out  1  fetch-redirect strobe.
- `pc_target`  out  ADDR_W  redirect address; valid only while `pc_redirect`=1.
- `epc`  out  ADDR_W  captured exception PC.
- `cause_code`  out  3  prioritized cause code.
- `cause_mask`  out  5  all cause lines captured. Bit order: [4]=write2_0, [3]=control, [2]=overflow, [1]=div_zero, [0]=invalid_addr.
- `exl`  out  1  exception level; 1 while servicing.
- `double_fault`  out  1  sticky nested-exception indicator.

## Operation
- Trigger = `exc_flag` OR any cause line.
- States: IDLE, FLUSH, REDIRECT, HANDLER, RETURN. All outputs are registered or Moore-decoded from the state register.

IDLE:
- On trigger: `epc` <= `exc_pc`; `cause_mask` <= cause lines; `exl` <= 1; go to FLUSH.
- `cause_code` priority: invalid_addr=1 > div_zero=2 > overflow=3 > control=4 > write2_0=5.
- `exc_flag`=1 with all cause lines 0 gives code 7 (unknown).
- `eret` in IDLE is ignored.

FLUSH:
- `flush`=1 for exactly this state.
- Unconditionally go to REDIRECT.

REDIRECT:
- `pc_redirect`=1, `pc_target`=VECTOR_ADDR.
- Unconditionally go to HANDLER.

HANDLER:
- Wait for `eret`. On `eret`, go to RETURN.
- A trigger while `exl`=1 (FLUSH, REDIRECT, HANDLER, RETURN) is not captured: `epc`/`cause_*` are unchanged and `double_fault` <= 1.
- Trigger and `eret` in the same HANDLER cycle: `eret` is honoured and `double_fault` is set.

RETURN:
- `pc_redirect`=1, `pc_target` = `epc` + 4, truncated to ADDR_W bits (wraps at 2^ADDR_W).
- Go to IDLE; `exl` <= 0 on that edge.
- `epc` and `cause_*` keep their values until the next capture.

General rules:
- `eret` outside HANDLER is ignored.
- `pc_target` = 0 whenever `pc_redirect`=0.
- `double_fault` is cleared only by reset.

Reset (asserted at any time, including mid-sequence):
- State goes to IDLE immediately.
- All outputs 0: `flush`, `pc_redirect`, `pc_target`, `epc`, `cause_code`, `cause_mask`, `exl`, `double_fault`.

## Timing
- Trigger sampled at edge k.
- Cycle after k: `flush`=1, `exl`=1, `epc`/`cause_*` valid.
- Cycle after k+1: `pc_redirect`=1 with `pc_target`=VECTOR_ADDR.
- From edge k+2: HANDLER.
- Latency: trigger to vector redirect = 2 cycles. `eret` to return redirect = 1 cycle.
- `flush` and `pc_redirect` are each 1-cycle pulses per event; they are never high together.
- A new exception can be captured in IDLE on the edge immediately after RETURN.
- Reset deassertion is synchronised by the integrator; the first active edge after release may capture a trigger.

## Test plan
- Overflow only, `exc_pc`=0x0000_0040 → `flush` pulse 1 cycle later, then redirect to 0x180; `epc`=0x40, `cause_code`=3, `cause_mask`=5'b00100, `exl`=1.
- Simultaneous invalid_addr + div_zero + write2_0 → `cause_code`=1, `cause_mask`=5'b10011. Then `eret` → one cycle later `pc_redirect` with `pc_target`=epc+4; `exl`=0 after.
- `exc_flag`=1 with no cause lines → `cause_code`=7, normal flush/redirect sequence.
- Second trigger during HANDLER with `exc_pc`=0x100 → `epc`/`cause_*` unchanged, `double_fault`=1, persists through `eret` until reset.
- `exc_pc`=0xFFFF_FFFC, then `eret` → `pc_target`=0x0000_0000 (wrap). `eret` pulsed in IDLE → no redirect.
- Assert `rst_n`=0 during REDIRECT → all outputs 0 asynchronously. After release, a trigger restarts the full sequence from IDLE.
